// File: rtl/kudu_dv_mem_cmd_tracker_if.sv
// Request/response/record bundle for kudu_dv_mem_cmd_tracker.
// master = stimulus/bus side, slave = tracker.
interface kudu_dv_mem_cmd_tracker_if #(
  parameter int DataW = 65,
  parameter int AddrW = 30
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [3:0]                req_be_i;
  logic [AddrW-1:0]          req_addr_i;
  logic [DataW-1:0]          req_wdata_i;
  logic                      req_is_cap_i;
  logic                      req_is_lrsc_i;
  logic [7:0]                req_flag_i;
  logic                      rsp_valid_i;
  logic [DataW-1:0]          rsp_rdata_i;
  logic                      rsp_err_i;
  logic                      rsp_sc_i;
  logic                      cmd_valid_o;
  logic                      cmd_ready_i;
  logic [17+AddrW+2*DataW-1:0] cmd_o;
  logic                      orphan_err_o;
  logic                      sc_mismatch_o;
  logic                      timeout_o;
  logic [31:0]               txn_cnt_o;

  modport master (
    output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
           req_is_cap_i, req_is_lrsc_i, req_flag_i,
           rsp_valid_i, rsp_rdata_i, rsp_err_i, rsp_sc_i, cmd_ready_i,
    input  req_ready_o, cmd_valid_o, cmd_o, orphan_err_o, sc_mismatch_o,
           timeout_o, txn_cnt_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
           req_is_cap_i, req_is_lrsc_i, req_flag_i,
           rsp_valid_i, rsp_rdata_i, rsp_err_i, rsp_sc_i, cmd_ready_i,
    output req_ready_o, cmd_valid_o, cmd_o, orphan_err_o, sc_mismatch_o,
           timeout_o, txn_cnt_o
  );
endinterface

// File: rtl/kudu_dv_mem_cmd_tracker.sv
// Pairs in-order mem requests with responses into FWFT mem_cmd records; >=1 cycle req->rsp.
// Requests stall when pending or pending+out would exceed capacity; KUDU_DV_MEM_TIMEOUT_EN adds a head-age watchdog.
module kudu_dv_mem_cmd_tracker #(
  parameter int DataW          = 65,
  parameter int AddrW          = 30,
  parameter int MaxOutstanding = 4,
  parameter int OutDepth       = 8,
  parameter int TimeoutCycles  = 1024
) (
  input logic                      clk_i,
  input logic                      rst_i,
  kudu_dv_mem_cmd_tracker_if.slave bus
);
  localparam int PPW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int OPW = (OutDepth > 1) ? $clog2(OutDepth) : 1;
  localparam int CW  = $clog2(OutDepth + 1) + 1;
  localparam logic [CW-1:0]  MaxC  = CW'(MaxOutstanding);
  localparam logic [CW-1:0]  DepC  = CW'(OutDepth);
  localparam logic [PPW-1:0] PLast = PPW'(MaxOutstanding - 1);
  localparam logic [OPW-1:0] OLast = OPW'(OutDepth - 1);

  typedef struct packed {
    logic [7:0]       flag;
    logic             is_cap;
    logic             is_lrsc;
    logic             we;
    logic [3:0]       be;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } req_t;

  typedef struct packed {
    req_t             req;
    logic [DataW-1:0] rdata;
    logic             err;
    logic             sc_resp;
  } cmd_t;

  req_t pend_mem [MaxOutstanding];
  cmd_t out_mem  [OutDepth];

  logic [PPW-1:0]   pend_wr_q, pend_rd_q;
  logic [OPW-1:0]   out_wr_q, out_rd_q;
  logic [CW-1:0]    pend_cnt_q, pend_cnt_d, out_cnt_q, out_cnt_d;
  logic [31:0]      txn_cnt_q;
  logic             orphan_q, sc_mis_q, resv_valid_q;
  logic [AddrW-1:0] resv_addr_q;

  logic req_ready, req_fire, rsp_hit, cmd_valid, cmd_fire, sc_expect;
  req_t head, req_in;
  cmd_t rec;

  function automatic logic [PPW-1:0] pinc(input logic [PPW-1:0] p);
    return (p == PLast) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OPW-1:0] oinc(input logic [OPW-1:0] p);
    return (p == OLast) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req_ready   = (pend_cnt_q < MaxC) && ((pend_cnt_q + out_cnt_q) < DepC);
    req_fire    = bus.req_valid_i && req_ready;
    rsp_hit     = bus.rsp_valid_i && (pend_cnt_q != '0);
    cmd_valid   = (out_cnt_q != '0);
    cmd_fire    = cmd_valid && bus.cmd_ready_i;
    head        = pend_mem[pend_rd_q];
    req_in      = '{flag: bus.req_flag_i, is_cap: bus.req_is_cap_i,
                    is_lrsc: bus.req_is_lrsc_i, we: bus.req_we_i,
                    be: bus.req_be_i, addr: bus.req_addr_i,
                    wdata: bus.req_wdata_i};
    rec.req     = head;
    rec.rdata   = head.we ? '0 : bus.rsp_rdata_i;
    rec.err     = bus.rsp_err_i;
    rec.sc_resp = head.is_lrsc && head.we && bus.rsp_sc_i;
    sc_expect   = resv_valid_q && (resv_addr_q == head.addr) && !bus.rsp_err_i;
    pend_cnt_d  = pend_cnt_q + CW'(req_fire) - CW'(rsp_hit);
    out_cnt_d   = out_cnt_q + CW'(rsp_hit) - CW'(cmd_fire);
  end

  // Storage is not reset; the counts alone define what is live.
  always_ff @(posedge clk_i) begin
    if (req_fire) pend_mem[pend_wr_q] <= req_in;
    if (rsp_hit)  out_mem[out_wr_q]   <= rec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_wr_q    <= '0;
      pend_rd_q    <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      pend_cnt_q   <= '0;
      out_cnt_q    <= '0;
      txn_cnt_q    <= '0;
      orphan_q     <= 1'b0;
      sc_mis_q     <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      out_cnt_q  <= out_cnt_d;
      if (req_fire) pend_wr_q <= pinc(pend_wr_q);
      if (rsp_hit) begin
        pend_rd_q <= pinc(pend_rd_q);
        out_wr_q  <= oinc(out_wr_q);
      end
      if (cmd_fire) begin
        out_rd_q  <= oinc(out_rd_q);
        txn_cnt_q <= txn_cnt_q + 32'd1;
      end
      if (bus.rsp_valid_i && (pend_cnt_q == '0)) orphan_q <= 1'b1;
      if (rsp_hit) begin
        if (head.is_lrsc && !head.we) begin
          if (!bus.rsp_err_i) begin
            resv_valid_q <= 1'b1;
            resv_addr_q  <= head.addr;
          end
        end else if (head.is_lrsc && head.we) begin
          if (bus.rsp_sc_i != sc_expect) sc_mis_q <= 1'b1;
          resv_valid_q <= 1'b0;
        end else if (head.we && !bus.rsp_err_i && (head.addr == resv_addr_q)) begin
          resv_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef KUDU_DV_MEM_TIMEOUT_EN
  logic [31:0] age_q, age_d;
  logic        timeout_q;

  // Compare the next age so the flag lands exactly TimeoutCycles after acceptance.
  always_comb age_d = ((pend_cnt_q == '0) || rsp_hit) ? 32'd0 : age_q + 32'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      age_q <= age_d;
      if (age_d == 32'(TimeoutCycles)) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
  assign bus.timeout_o      = 1'b0;
`endif

  assign bus.req_ready_o   = req_ready;
  assign bus.cmd_valid_o   = cmd_valid;
  assign bus.cmd_o         = cmd_valid ? out_mem[out_rd_q] : '0;
  assign bus.orphan_err_o  = orphan_q;
  assign bus.sc_mismatch_o = sc_mis_q;
  assign bus.txn_cnt_o     = txn_cnt_q;
endmodule

// File: doc/kudu_dv_mem_cmd_tracker.md
Name: kudu_dv_mem_cmd_tracker

Overview:
- DV-side tracker that pairs in-order memory requests with their responses and emits one completed mem_cmd record per transaction on a valid/ready stream.
- The stream feeds scoreboards and loggers.
- Parametrised successor of the fixed 65-bit/30-bit mem_cmd record: generalised data width, address width, outstanding depth and output depth.
- Adds LR/SC reservation checking, orphan-response detection and a completion counter.

Parameters:
DataW, 65, data width including capability tag bit
AddrW, 30, word-address width
MaxOutstanding, 4, pending-request queue depth (>=1)
OutDepth, 8, completed-record FIFO depth (>= MaxOutstanding)
TimeoutCycles, 1024, head-of-queue response timeout (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  write enable
req_be_i  in  4  byte enables
req_addr_i  in  AddrW  word address
req_wdata_i  in  DataW  write data
req_is_cap_i  in  1  capability access
req_is_lrsc_i  in  1  LR (we=0) or SC (we=1)
req_flag_i  in  8  opaque tag, passed through
rsp_valid_i  in  1  response valid; no backpressure; in order
rsp_rdata_i  in  DataW  read data
rsp_err_i  in  1  bus error
rsp_sc_i  in  1  SC result, 1 = success
cmd_valid_o  out  1  record valid
cmd_ready_i  in  1  record consumed when valid&ready
cmd_o  out  17+AddrW+2*DataW  {flag, is_cap, is_lrsc, we, be, addr, wdata, rdata, err, sc_resp}, MSB first; 177 bits at defaults
orphan_err_o  out  1  sticky: response with no pending request
sc_mismatch_o  out  1  sticky: SC result disagrees with reservation model
timeout_o  out  1  sticky: head request exceeded TimeoutCycles
txn_cnt_o  out  32  completed-record count, wraps

Behaviour:
- Reset: all queues empty, all counts 0, reservation invalid. Outputs at reset: req_ready_o=1, cmd_valid_o=0, cmd_o=0, all sticky flags 0, txn_cnt_o=0.
- Request acceptance:
  - req_ready_o = (pend_cnt < MaxOutstanding) && (pend_cnt + out_cnt < OutDepth).
  - A request therefore reserves an output slot, so a response is never dropped for lack of space.
  - An accepted request is pushed to the pending FIFO on the next edge.
- Response handling:
  - When rsp_valid_i=1 and pend_cnt>0: pop the pending head, merge the response fields, and push the record into the out FIFO on the same edge.
  - rdata field = rsp_rdata_i when we=0, 0 when we=1.
  - sc_resp field = rsp_sc_i for SC, 0 otherwise.
  - Minimum request-to-response latency is 1 cycle. A request accepted in cycle N cannot match a response in cycle N.
- Orphan: rsp_valid_i with pend_cnt==0 (evaluated before same-cycle push) sets orphan_err_o; the response is discarded and no record is produced.
- Out FIFO:
  - First-word-fall-through. cmd_o is stable while cmd_valid_o=1 and cmd_ready_i=0.
  - Same-cycle push and pop are legal at any occupancy, including full: count unchanged.
  - txn_cnt_o increments on each pop (valid&ready) and wraps 0xFFFFFFFF -> 0.
- Reservation model, updated at response time:
  - LR with err=0: resv_valid=1, resv_addr=addr.
  - LR with err=1: no change.
  - SC: expected = resv_valid && resv_addr==addr && !err. If rsp_sc_i != expected, set sc_mismatch_o. Then clear resv_valid regardless of outcome.
  - Non-SC write with err=0 to resv_addr: clear resv_valid.
- Wrap-around: pending and out FIFOs are circular, with pointer width clog2(depth). Depths need not be a power of two; pointers wrap explicitly at depth-1.
- Reset asserted mid-operation: pending and out contents are discarded, sticky flags clear, and the reservation is invalidated asynchronously.

Optional Feature:
- KUDU_DV_MEM_TIMEOUT_EN defined:
  - A 32-bit age counter runs while pend_cnt>0 and resets to 0 on every pop or when pending is empty.
  - When age reaches TimeoutCycles, set timeout_o (sticky).
- Not defined: no counter is built; timeout_o tied to 0.

Test Plan:
- Reset only -> req_ready_o=1, cmd_valid_o=0, all flags 0, txn_cnt_o=0.
- Read req addr=0x100 flag=0x5A, response 2 cycles later rdata=0x1_DEADBEEF -> one record: we=0, addr=0x100, rdata=0x1_DEADBEEF, flag=0x5A, err=0; txn_cnt_o=1 after consume.
- 4 reads back-to-back with cmd_ready_i=0, MaxOutstanding=4, OutDepth=8 -> 5th request stalls (req_ready_o=0); 4 responses give 4 records in request order; req_ready_o rises after the first pop.
- LR 0x40 ok; SC 0x40 with rsp_sc_i=1 -> sc_mismatch_o=0. Second SC 0x40 with rsp_sc_i=1 -> sc_mismatch_o=1 (reservation was cleared).
- rsp_valid_i pulse with empty pending -> orphan_err_o=1, no record, txn_cnt_o unchanged.
- With KUDU_DV_MEM_TIMEOUT_EN and TimeoutCycles=16: request with no response -> timeout_o=1 exactly 16 cycles after acceptance; without the macro timeout_o stays 0.
